// File: rtl/niosii_system_data_format_adapter_reader_pkg.sv
// Shared definitions for the data format adapter lookahead RAM: read latency and wrap-bit pointer type.
package niosII_system_dfa_pkg;

    localparam int READ_LATENCY      = 2;
    localparam int DFA_ADDRESS_WIDTH = 4;

    // One extra MSB wrap bit so that full and empty can be told apart.
    function automatic int ptr_width(input int address_width);
        return address_width + 1;
    endfunction

    typedef logic [DFA_ADDRESS_WIDTH:0] dfa_ptr_t;

endpackage

// File: rtl/niosii_system_data_format_adapter_reader_if.sv
// RAM read port plus Avalon-ST source between the reader (master) and its RAM/sink (slave).
interface niosii_system_data_format_adapter_reader_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
);
    logic [ADDRESS_WIDTH-1:0] rd0_address;
    logic [DATA_WIDTH-1:0]    rd0_readdata;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output rd0_address,
        input  rd0_readdata,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  rd0_address,
        output rd0_readdata,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/niosii_system_data_format_adapter_reader_skid_fifo.sv
// Shift-register skid FIFO: entry 0 is the registered head, count feeds the reader's credit check.
module niosII_system_dfa_skid_fifo #(
    parameter int  DATA_WIDTH = 8,
    parameter int  SKID_DEPTH = 4,
    localparam int CNT_W      = $clog2(SKID_DEPTH) + 1,
    localparam int IDX_W      = $clog2(SKID_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  empty_o,
    output logic [CNT_W-1:0]      count_o
);
    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [CNT_W-1:0]      count_q;
    logic [IDX_W-1:0]      wr_idx;
    logic                  do_push;
    logic                  do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != '0) && !flush_i;
        do_push = push_i && !flush_i;
        // A same-cycle pop shifts everything down, so the new word lands one slot lower.
        wr_idx  = do_pop ? IDX_W'(count_q - 1'b1) : IDX_W'(count_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < SKID_DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
            end
            if (do_push) mem_q[wr_idx] <= data_i;
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_o  = mem_q[0];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assert property (@(posedge clk) disable iff (!reset_n)
        !(do_push && !do_pop && (count_q == CNT_W'(SKID_DEPTH))));

endmodule

// File: rtl/niosii_system_data_format_adapter_reader.sv
// Read-side controller for the adapter's lookahead RAM: credit-gated reads, 2-cycle pipeline, skid FIFO.
// Optional saturating starve counter port enabled by NIOSII_DFA_READER_STARVE_CNT_EN.
module niosii_system_data_format_adapter_reader
    import niosII_system_dfa_pkg::*;
#(
    parameter int  DATA_WIDTH    = 8,
    parameter int  ADDRESS_WIDTH = 4,
    parameter int  SKID_DEPTH    = 4,
    localparam int PTR_W         = ptr_width(ADDRESS_WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PTR_W-1:0] wr_ptr_i,
    output logic [PTR_W-1:0] rd_ptr_o,
    input  logic             flush_i,
    niosii_system_data_format_adapter_reader_if.master bus
`ifdef NIOSII_DFA_READER_STARVE_CNT_EN
    ,
    output logic [15:0]      starve_count_o
`endif
);
    localparam int CNT_W = $clog2(SKID_DEPTH) + 1;

    if (SKID_DEPTH < READ_LATENCY + 1 || (SKID_DEPTH & (SKID_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("SKID_DEPTH must be a power of two and at least READ_LATENCY+1");
    end

    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      avail;
    logic                  p1_q, p1_d;
    logic                  p2_q, p2_d;
    logic                  issue, push, pop;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        credits_used;
    logic [DATA_WIDTH-1:0] fifo_head;

    always_comb begin
        avail = wr_ptr_i - rd_ptr_q;
        pop   = !fifo_empty && bus.out_ready;
        // A pop this cycle frees its slot before the issue decision is made.
        credits_used = (CNT_W+1)'(p1_q) + (CNT_W+1)'(p2_q) + (CNT_W+1)'(fifo_count)
                     - (CNT_W+1)'(pop);
        issue = (avail != '0) && (credits_used < (CNT_W+1)'(SKID_DEPTH)) && !flush_i;

        rd_ptr_d = rd_ptr_q;
        if (flush_i)    rd_ptr_d = wr_ptr_i;
        else if (issue) rd_ptr_d = rd_ptr_q + 1'b1;

        p1_d = issue;
        p2_d = p1_q && !flush_i;
        push = p2_q && !flush_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            p1_q     <= 1'b0;
            p2_q     <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
        end
    end

    niosII_system_dfa_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush_i),
        .data_i  (bus.rd0_readdata),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.rd0_address = rd_ptr_q[ADDRESS_WIDTH-1:0];
    assign bus.out_data    = fifo_head;
    assign bus.out_valid   = !fifo_empty;
    assign rd_ptr_o        = rd_ptr_q;

`ifdef NIOSII_DFA_READER_STARVE_CNT_EN
    logic [15:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (flush_i)                                                  starve_d = '0;
        else if (bus.out_ready && fifo_empty && starve_q != 16'hFFFF) starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end

    assign starve_count_o = starve_q;
`endif

endmodule

// File: tb/tb_niosii_system_data_format_adapter_reader.sv
// Scoreboard bench for the lookahead RAM reader; starve counter checks built with NIOSII_DFA_READER_STARVE_CNT_EN.
module tb_niosii_system_data_format_adapter_reader;
    import niosII_system_dfa_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic     clk     = 1'b0;
    logic     reset_n = 1'b0;
    logic     flush   = 1'b0;
    dfa_ptr_t wr_ptr  = '0;
    logic [AW:0] rd_ptr;
`ifdef NIOSII_DFA_READER_STARVE_CNT_EN
    logic [15:0] starve_count;
`endif

    niosii_system_data_format_adapter_reader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    niosii_system_data_format_adapter_reader #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .SKID_DEPTH    (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_ptr_i (wr_ptr),
        .rd_ptr_o (rd_ptr),
        .flush_i  (flush),
        .bus      (bus)
`ifdef NIOSII_DFA_READER_STARVE_CNT_EN
        ,
        .starve_count_o (starve_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM with a 2-cycle read port.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_r1, ram_r2;
    always @(posedge clk) begin
        ram_r1 <= ram[bus.rd0_address];
        ram_r2 <= ram_r1;
    end
    assign bus.rd0_readdata = ram_r2;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int unsigned wr_cnt = 0;    // words exposed by the writer
    int unsigned cons_cnt = 0;  // words popped or discarded by flush
    logic [DW-1:0] exp_q [$];
    int            pop_t [$];
    logic [DW-1:0] exp_word;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted symbol must be the oldest outstanding written word.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready && !flush) begin
            checks++;
            cons_cnt++;
            pop_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %0h, expected no word", bus.out_data);
            end else begin
                exp_word = exp_q.pop_front();
                if (bus.out_data !== exp_word) begin
                    errors++;
                    $display("FAIL sb_data: got %0h, expected %0h", bus.out_data, exp_word);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        ram[wr_cnt[AW-1:0]] = d;
        exp_q.push_back(d);
        wr_cnt++;
        wr_ptr = dfa_ptr_t'(wr_cnt);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        exp_q.delete();
        cons_cnt = wr_cnt;
        tick();
        flush = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        wr_cnt   = 0;
        cons_cnt = 0;
        wr_ptr   = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic drain(input string name);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check({name, "_left"}, 32'(exp_q.size()), 32'd0);
        repeat (4) tick();
        check({name, "_idle"}, 32'(bus.out_valid), 32'd0);
    endtask

    int          edges;
    int unsigned base;

    initial begin
        // Reset with three words already exposed.
        bus.out_ready = 1'b1;
        write_word(8'hA5);
        write_word(8'h3C);
        write_word(8'h7E);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_ptr",    32'(rd_ptr),        32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        pop_t.delete();
        edges = 0;
        while (edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.out_valid) break;
        end
        check("rst_latency", 32'(edges), 32'd3);
        repeat (4) tick();
        check("rst_rd_ptr_after", 32'(rd_ptr), 32'd3);
        check("rst_pop_count", 32'(pop_t.size()), 32'd3);
        if (pop_t.size() == 3) check("rst_back_to_back", 32'(pop_t[2] - pop_t[0]), 32'd2);

        // Reset in the middle of a stalled burst discards everything.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) write_word(8'(8'hE0 + i));
        repeat (3) tick();
        do_reset();
        bus.out_ready = 1'b1;
        repeat (8) tick();
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_rd_ptr",    32'(rd_ptr),        32'd0);

        // Streaming: 40 words through the 16-entry RAM.
        pop_t.delete();
        for (int i = 0; i < 40; i++) begin
            for (int w = 0; w < 100 && (wr_cnt - cons_cnt) >= DEPTH; w++) tick();
            write_word(8'(i));
            tick();
        end
        drain("stream");
        check("stream_rd_ptr", 32'(rd_ptr), 32'd8);
        check("stream_pops", 32'(pop_t.size()), 32'd40);
        if (pop_t.size() == 40) check("stream_no_gaps", 32'(pop_t[39] - pop_t[0]), 32'd39);

        // Backpressure: ten words exposed, sink stalled.
        base = wr_cnt;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) write_word(8'(8'h40 + i));
        repeat (20) tick();
        check("bp_rd_ptr_stall", 32'(rd_ptr), 32'((base + 4) % 32));
        check("bp_out_valid",    32'(bus.out_valid), 32'd1);
        check("bp_out_data",     32'(bus.out_data),  32'h40);
        drain("bp");
        check("bp_rd_ptr_end", 32'(rd_ptr), 32'(wr_cnt % 32));

        // Full RAM: wr_ptr = 5'b10000 against rd_ptr = 0.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_word(8'($urandom));
        repeat (10) tick();
        check("full_rd_ptr_stall", 32'(rd_ptr), 32'd4);
        drain("full");
        check("full_rd_ptr_end", 32'(rd_ptr), 32'd16);

        // Flush mid-burst with reads in flight and words buffered.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) write_word(8'(8'h60 + i));
        repeat (3) tick();
        do_flush();
        check("flush_rd_ptr", 32'(rd_ptr), 32'(wr_ptr));
        @(negedge clk);
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (5) tick();
        check("flush_no_stale", 32'(bus.out_valid), 32'd0);
        write_word(8'h99);
        write_word(8'h9A);
        drain("flush");

        // Random traffic with random backpressure and occasional flushes.
        for (int n = 0; n < 3000; n++) begin
            bus.out_ready = ($urandom_range(3) != 0);
            if ($urandom_range(63) == 0) begin
                do_flush();
            end else begin
                if ($urandom_range(2) != 0 && (wr_cnt - cons_cnt) < DEPTH) write_word(8'($urandom));
                tick();
            end
        end
        drain("random");
        check("random_rd_ptr", 32'(rd_ptr), 32'(wr_cnt % 32));

`ifdef NIOSII_DFA_READER_STARVE_CNT_EN
        bus.out_ready = 1'b0;
        do_flush();
        check("starve_cleared", 32'(starve_count), 32'd0);
        bus.out_ready = 1'b1;
        repeat (7) tick();
        bus.out_ready = 1'b0;
        check("starve_seven", 32'(starve_count), 32'd7);
        do_flush();
        check("starve_flush", 32'(starve_count), 32'd0);
        bus.out_ready = 1'b1;
        repeat (70000) tick();
        check("starve_saturate", 32'(starve_count), 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
